// File: rtl/instr_encoder_loader_if.sv
// Descriptor stream and instruction-memory write port of the instruction
// encoder/loader. The slave side is the loader; the master side is the
// producer of descriptors that also owns the memory's ready signal.
interface instr_encoder_loader_if;
  // descriptor stream
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_imm;
  // instruction memory write port
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport slave (
    input  in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_ready
  );

  modport master (
    output in_valid, in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder / program loader.
// Packs R, I-ALU, LW, SW and BEQ descriptors into 32-bit words, buffers them
// in a DEPTH-entry FIFO and writes them to consecutive word addresses.
// Optional feature macro: LOADER_ERR_EN
//   defined   : illegal descriptors are consumed, dropped, and err pulses.
//   undefined : err is 0; illegal classes become NOP, BEQ ignores imm[0].
module instr_encoder_loader #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,      // active-low, asynchronous
  instr_encoder_loader_if.slave      bus,
  input  logic                       flush,
  output logic [15:0]                wr_count,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   addr_reg;
  logic [15:0]   wr_count_reg;

  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          illegal;
  logic [31:0]   enc_word;

  assign full   = (count_reg == CW'(DEPTH));
  assign empty  = (count_reg == '0);
  assign accept = bus.in_valid && !full;
  assign pop    = !empty && bus.mem_ready;

  assign bus.in_ready  = !full;
  assign bus.mem_we    = !empty;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = empty ? 32'h0 : fifo_mem[rd_ptr_reg];
  assign wr_count      = wr_count_reg;

`ifdef LOADER_ERR_EN
  logic err_reg;

  assign illegal = (bus.in_class > 3'd4) || ((bus.in_class == 3'd4) && bus.in_imm[0]);
  assign push    = accept && !illegal;
  assign err     = err_reg;

  // err pulses the cycle after an illegal descriptor is consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= accept && illegal && !flush;
    end
  end
`else
  assign illegal = 1'b0;
  assign push    = accept && !illegal;
  assign err     = 1'b0;
`endif

  // Field packing; unknown classes fall back to NOP (addi x0,x0,0)
  always_comb begin
    enc_word = 32'h0000_0013;
    case (bus.in_class)
      3'd0: enc_word = {(bus.in_alt ? 7'h20 : 7'h00), bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, bus.in_rd, 7'h33};
      3'd1: begin
        if (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101) begin
          // shifts: upper immediate bits carry only the arithmetic flag
          enc_word = {1'b0, bus.in_alt, 5'b0, bus.in_imm[4:0], bus.in_rs1,
                      bus.in_funct3, bus.in_rd, 7'h13};
        end else begin
          enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'h13};
        end
      end
      3'd2: enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'h03};
      3'd3: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010,
                        bus.in_imm[4:0], 7'h23};
      3'd4: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], 7'h63};
      default: enc_word = 32'h0000_0013;
    endcase
  end

  // FIFO storage: no reset needed, occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      fifo_mem[wr_ptr_reg] <= enc_word;
    end
  end

  // Pointers, occupancy, write address and completed-write counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      addr_reg     <= BASE_ADDR;
      wr_count_reg <= '0;
    end else if (flush) begin
      // flush discards any concurrent accept or pop; wr_count is kept
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      addr_reg   <= BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        addr_reg     <= addr_reg + 32'd4;
        wr_count_reg <= wr_count_reg + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed vector table,
// backpressure / flush / reset sequences, then randomized traffic checked
// against a queue-based reference model of the loader.
module tb_instr_encoder_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  typedef struct {
    int unsigned cls;
    int unsigned f3;
    int unsigned alt;
    int unsigned rd;
    int unsigned rs1;
    int unsigned rs2;
    int unsigned imm;
  } desc_t;

  typedef struct {
    desc_t       d;
    logic [31:0] exp;
    bit          legal;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] wr_count;
  logic        err;

  instr_encoder_loader_if bus();

  instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .wr_count (wr_count),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] q[$];
  logic [31:0] m_addr;
  logic [15:0] m_cnt;
  logic        m_err;
  desc_t       cur;
  bit          last_acc;

  function automatic logic [31:0] ref_encode(desc_t d);
    int unsigned w;
    int unsigned i12;
    i12 = d.imm & 32'hFFF;
    case (d.cls)
      0: w = ((d.alt != 0 ? 32'h20 : 32'h0) << 25) | (d.rs2 << 20) | (d.rs1 << 15)
             | (d.f3 << 12) | (d.rd << 7) | 32'h33;
      1: begin
        if (d.f3 == 1 || d.f3 == 5)
          w = (d.alt << 30) | ((d.imm & 31) << 20) | (d.rs1 << 15) | (d.f3 << 12)
              | (d.rd << 7) | 32'h13;
        else
          w = (i12 << 20) | (d.rs1 << 15) | (d.f3 << 12) | (d.rd << 7) | 32'h13;
      end
      2: w = (i12 << 20) | (d.rs1 << 15) | (2 << 12) | (d.rd << 7) | 32'h03;
      3: w = ((i12 >> 5) << 25) | (d.rs2 << 20) | (d.rs1 << 15) | (2 << 12)
             | ((i12 & 31) << 7) | 32'h23;
      4: w = (((d.imm >> 12) & 1) << 31) | (((d.imm >> 5) & 63) << 25) | (d.rs2 << 20)
             | (d.rs1 << 15) | (d.f3 << 12) | (((d.imm >> 1) & 15) << 8)
             | (((d.imm >> 11) & 1) << 7) | 32'h63;
      default: w = 32'h13;
    endcase
    return w;
  endfunction

  function automatic bit is_illegal(desc_t d);
`ifdef LOADER_ERR_EN
    return (d.cls >= 5) || (d.cls == 4 && (d.imm & 1) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic vec_t mk(int unsigned cls, int unsigned f3, int unsigned alt,
                              int unsigned rd, int unsigned rs1, int unsigned rs2,
                              int unsigned imm, logic [31:0] exp, bit legal);
    vec_t v;
    v.d.cls = cls; v.d.f3 = f3; v.d.alt = alt; v.d.rd = rd;
    v.d.rs1 = rs1; v.d.rs2 = rs2; v.d.imm = imm;
    v.exp = exp; v.legal = legal;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(desc_t d);
    cur           = d;
    bus.in_class  = 3'(d.cls);
    bus.in_funct3 = 3'(d.f3);
    bus.in_alt    = d.alt[0];
    bus.in_rd     = 5'(d.rd);
    bus.in_rs1    = 5'(d.rs1);
    bus.in_rs2    = 5'(d.rs2);
    bus.in_imm    = 13'(d.imm);
  endtask

  task automatic model_reset();
    q.delete();
    m_addr = BASE;
    m_cnt  = '0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs();
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    check("mem_we", 32'(bus.mem_we), 32'(q.size() > 0));
    check("mem_addr", bus.mem_addr, m_addr);
    check("mem_wdata", bus.mem_wdata, (q.size() > 0) ? q[0] : 32'h0);
    check("wr_count", 32'(wr_count), 32'(m_cnt));
    check("err", 32'(err), 32'(m_err));
  endtask

  // one clock: model next state from pre-edge inputs, compare at negedge
  task automatic cycle();
    bit acc;
    bit popping;
    acc      = bus.in_valid && (q.size() < DEPTH);
    popping  = (q.size() > 0) && bus.mem_ready;
    last_acc = acc && !flush;
    @(posedge clk);
    if (flush) begin
      q.delete();
      m_addr = BASE;
      m_err  = 1'b0;
    end else begin
      if (popping) begin
        void'(q.pop_front());
        m_addr = m_addr + 32'd4;
        m_cnt  = m_cnt + 16'd1;
      end
      if (acc && !is_illegal(cur)) q.push_back(ref_encode(cur));
      m_err = acc && is_illegal(cur);
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic desc_t rand_desc(bit allow_bad);
    desc_t d;
    if (allow_bad && ($urandom % 8 == 0)) d.cls = $urandom_range(5, 7);
    else                                  d.cls = $urandom_range(0, 4);
    d.f3  = $urandom_range(0, 7);
    d.alt = $urandom_range(0, 1);
    d.rd  = $urandom_range(0, 31);
    d.rs1 = $urandom_range(0, 31);
    d.rs2 = $urandom_range(0, 31);
    d.imm = $urandom & 32'h1FFF;
    if (!allow_bad && d.cls == 4) d.imm = d.imm & 32'h1FFE;
    return d;
  endfunction

  vec_t tbl[10];

  initial begin
    int   n_legal;
    bit   got;
    desc_t d;

`ifdef LOADER_ERR_EN
    localparam bit ODD_OK = 1'b0;
`else
    localparam bit ODD_OK = 1'b1;
`endif
    tbl[0] = mk(0, 0, 0, 3, 1, 2, 32'h0000, 32'h002081B3, 1'b1);  // add x3,x1,x2
    tbl[1] = mk(0, 0, 1, 3, 1, 2, 32'h0000, 32'h402081B3, 1'b1);  // sub x3,x1,x2
    tbl[2] = mk(2, 7, 0, 5, 0, 9, 32'h0008, 32'h00802283, 1'b1);  // lw x5,8(x0)
    tbl[3] = mk(3, 0, 0, 9, 0, 5, 32'h000C, 32'h00502623, 1'b1);  // sw x5,12(x0)
    tbl[4] = mk(4, 0, 0, 0, 1, 2, 32'h1FF8, 32'hFE208CE3, 1'b1);  // beq x1,x2,-8
    tbl[5] = mk(1, 0, 0, 1, 0, 0, 32'h1FFF, 32'hFFF00093, 1'b1);  // addi x1,x0,-1
    tbl[6] = mk(1, 5, 1, 5, 6, 0, 32'h0FE3, 32'h40335293, 1'b1);  // srai x5,x6,3
    tbl[7] = mk(1, 1, 0, 1, 1, 0, 32'h0FE3, 32'h00309093, 1'b1);  // slli x1,x1,3
    tbl[8] = mk(6, 0, 0, 1, 1, 1, 32'h0000, 32'h00000013, ODD_OK); // illegal class
    tbl[9] = mk(4, 0, 0, 0, 1, 2, 32'h0011, 32'h00208863, ODD_OK); // beq odd imm

    bus.in_valid  = 1'b0;
    bus.mem_ready = 1'b0;
    drive(tbl[0].d);
    model_reset();

    // reset values
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // directed vector table, mem_ready held high
    n_legal = 0;
    bus.mem_ready = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].d);
      bus.in_valid = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      if (tbl[i].legal) begin
        check($sformatf("vec%0d_word", i), bus.mem_wdata, tbl[i].exp);
        check($sformatf("vec%0d_addr", i), bus.mem_addr, BASE + 32'(4 * n_legal));
        n_legal++;
      end else begin
        check($sformatf("vec%0d_dropped", i), 32'(bus.mem_we), 32'h0);
        check($sformatf("vec%0d_err", i), 32'(err), 32'h1);
      end
    end
    cycle();
    check("tbl_wr_count", 32'(wr_count), 32'(n_legal));

    // backpressure: five descriptors into a four-entry FIFO
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(rand_desc(1'b0));
      bus.in_valid = 1'b1;
      cycle();
    end
    check("bp_full_ready", 32'(bus.in_ready), 32'h0);
    drive(rand_desc(1'b0));
    cycle();
    cycle();
    check("bp_hold_addr", bus.mem_addr, m_addr);
    bus.mem_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cycle();
      got = last_acc;
    end
    check("bp_fifth_accepted", 32'(got), 32'h1);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) cycle();

    // flush with three words buffered
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rand_desc(1'b0));
      bus.in_valid = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    flush = 1'b1;
    bus.mem_ready = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_we", 32'(bus.mem_we), 32'h0);
    check("flush_addr", bus.mem_addr, BASE);

    // asynchronous reset mid-burst
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(rand_desc(1'b0));
      bus.in_valid = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    cycle();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      d = rand_desc(1'b1);
      drive(d);
      bus.in_valid  = ($urandom % 4) != 0;
      bus.mem_ready = ($urandom % 3) != 0;
      flush         = ($urandom % 25) == 0;
      cycle();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Streams RV32I instruction descriptors into the instruction memory. It is the encoding counterpart of the pipeline's decode path: it accepts field-level descriptors over a valid/ready handshake and packs each one into a 32-bit instruction word. It covers exactly the instruction classes the control unit decodes: R-type, I-type ALU, lw, sw and beq. Encoded words are buffered in a small FIFO and written to consecutive word addresses through a write port with backpressure. The block is used for program loading and self-test of the pipeline.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- BASE_ADDR, 32'h0: first write address, and the address restored by flush.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  descriptor present.
- in_ready  output  1  descriptor can be accepted.
- in_class  input  3  0=R, 1=I-ALU, 2=LW, 3=SW, 4=BEQ; 5–7 are illegal.
- in_funct3  input  3  funct3 for R, I-ALU and BEQ; ignored for LW and SW, which force 3'b010.
- in_alt  input  1  funct7[5] for R; imm[10] for I-ALU funct3=101.
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_imm  input  13  immediate, two's complement. I and S use [11:0]. B uses [12:0], and [0] must be 0.
- mem_we  output  1  write request.
- mem_addr  output  32  write word address (byte address, word aligned).
- mem_wdata  output  32  encoded instruction.
- mem_ready  input  1  write accepted this cycle.
- flush  input  1  synchronous; empties the FIFO and restores the address.
- wr_count  output  16  writes completed, wraps.
- err  output  1  one-cycle pulse on an illegal descriptor.

## Operation
- **Accept:** a descriptor is taken on a rising edge with in_valid && in_ready. in_ready = !full; there is no pass-through when full.
- **Encoding:** combinational at the FIFO input; the FIFO stores finished words.
  - R: {alt?7'h20:7'h00, rs2, rs1, f3, rd, 7'h33}.
  - I-ALU: {imm[11:0], rs1, f3, rd, 7'h13}. For f3=001 and f3=101, bits [31:25] become {1'b0, alt, 5'b0} and bits [24:20] = imm[4:0].
  - LW: {imm[11:0], rs1, 3'b010, rd, 7'h03}.
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63}.
- **Illegal descriptors:** in_class 5–7, or BEQ with imm[0]=1. The descriptor is consumed, nothing is pushed, and err pulses on the following cycle.
- **Write side:** mem_we = !empty; mem_wdata = head entry; mem_addr = address register.
  - On mem_we && mem_ready: pop, add 4 to mem_addr (wraps modulo 2^32), increment wr_count.
- **Push and pop in the same cycle:** both occur and occupancy is unchanged. When full, a pop frees in_ready only on the next cycle.
- **flush:**
  - Occupancy goes to 0 and mem_addr returns to BASE_ADDR.
  - wr_count is kept.
  - A concurrent accept or pop is discarded; the flush wins.

## Timing
- Reset values (asynchronous, rst=0): in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, wr_count=0, err=0, FIFO empty.
- Reset asserted mid-burst drops all buffered words immediately. No write is completed during reset.
- Latency: a descriptor accepted at edge N appears as mem_we=1 with its word in cycle N+1. The earliest write completion is edge N+1.
- Sustained throughput is one word per cycle when mem_ready is held at 1.
- mem_addr, mem_wdata and mem_we stay stable while mem_we=1 && mem_ready=0.
- Words are written in acceptance order.

## Configuration
- **LOADER_ERR_EN defined:** illegal descriptors are dropped and err pulses, as described above.
- **LOADER_ERR_EN undefined:**
  - err is tied to 0.
  - An illegal class is encoded as NOP 32'h00000013 and pushed normally.
  - BEQ with imm[0]=1 is encoded with imm[0] ignored.

## Test plan
- R add x3,x1,x2 (class0, f3=0, alt0, rd3, rs1=1, rs2=2), mem_ready=1 -> mem_wdata=32'h002081B3 at mem_addr=BASE_ADDR. With alt=1 -> 32'h402081B3 at BASE_ADDR+4.
- LW x5,8(x0) then SW x5,12(x0) -> 32'h00802283, then 32'h00502623, at consecutive addresses; wr_count=2.
- BEQ x1,x2,-8 (in_imm=13'h1FF8) -> 32'hFE208CE3.
- mem_ready=0, push 5 descriptors:
  - in_ready drops after the 4th.
  - Set mem_ready=1 -> four writes at BASE, +4, +8, +12 in order.
  - The 5th descriptor is accepted once space frees.
- class=6 -> with LOADER_ERR_EN: err=1 for one cycle and no write. Without the macro: writes 32'h00000013.
- Three words buffered:
  - Pulse flush -> mem_we=0 next cycle and mem_addr=BASE_ADDR.
  - Repeat with rst low mid-burst -> all outputs at reset values asynchronously.
